ann_layer_sequencer: RTL

- Top-level scheduler for the 2-layer ANN.
- Sequences layer-1 MAC → shared relu_block → layer-2 MAC → same relu_block, then signals completion.
- Owns the relu_block control pins (rst_vals, layer_done) and the relu input mux.
- Registers each layer's activated vector for downstream consumers, and guards every wait with a timeout.

---
 rtl/ann_layer_sequencer_pkg.sv | 25 ++
 rtl/ann_layer_sequencer_if.sv | 39 +++
 rtl/ann_layer_sequencer_timeout_ctr.sv | 27 ++
 rtl/ann_layer_sequencer.sv | 124 ++++++++++++
 4 files changed

// File: rtl/ann_layer_sequencer_pkg.sv
// Shared types and constants for the two-layer ANN control path.
package ann_ctrl_pkg;

    localparam int DEFAULT_DATAWIDTH = 11;
    localparam int DEFAULT_ROWS      = 4;
    localparam int DEFAULT_TIMEOUT   = 255;

    localparam logic LAYER1 = 1'b0;
    localparam logic LAYER2 = 1'b1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        L1_MAC = 3'd1,
        L1_ACT = 3'd2,
        L2_MAC = 3'd3,
        L2_ACT = 3'd4,
        FIN    = 3'd5,
        ERR    = 3'd6
    } seq_state_t;

    function automatic logic is_active(input seq_state_t s);
        return (s == L1_MAC) || (s == L1_ACT) || (s == L2_MAC) || (s == L2_ACT);
    endfunction

endpackage

// File: rtl/ann_layer_sequencer_if.sv
// Handshake bundle between the sequencer, the MAC array, the relu_block and the consumer.
interface ann_layer_sequencer_if
    import ann_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int ROWS      = DEFAULT_ROWS
);
    logic                      start;
    logic                      busy;
    logic                      done;
    logic                      err_timeout;
    logic                      mac_start;
    logic                      mac_layer;
    logic                      mac_done;
    logic [ROWS*DATAWIDTH-1:0] l1_acc;
    logic [ROWS*DATAWIDTH-1:0] l2_acc;
    logic                      relu_rst_vals;
    logic                      relu_layer_done;
    logic [ROWS*DATAWIDTH-1:0] relu_in;
    logic [ROWS*DATAWIDTH-1:0] relu_out;
    logic                      relu_done;
    logic                      act_valid;
    logic                      act_layer;
    logic [ROWS*DATAWIDTH-1:0] act_data;

    modport master (
        input  start, mac_done, l1_acc, l2_acc, relu_out, relu_done,
        output busy, done, err_timeout, mac_start, mac_layer,
               relu_rst_vals, relu_layer_done, relu_in,
               act_valid, act_layer, act_data
    );

    modport slave (
        output start, mac_done, l1_acc, l2_acc, relu_out, relu_done,
        input  busy, done, err_timeout, mac_start, mac_layer,
               relu_rst_vals, relu_layer_done, relu_in,
               act_valid, act_layer, act_data
    );
endinterface

// File: rtl/ann_layer_sequencer_timeout_ctr.sv
// Wait-state watchdog: counts while enabled, saturates at TIMEOUT and flags expiry.
module seq_timeout_ctr #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count;

    assign expired = (count == CW'(TIMEOUT));

    // Counter clears on request and otherwise advances while enabled, holding at the limit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && !expired) begin
            count <= count + CW'(1);
        end
    end
endmodule

// File: rtl/ann_layer_sequencer.sv
// Scheduler for the 2-layer ANN: layer-1 MAC, relu, layer-2 MAC, relu, then done.
module ann_layer_sequencer
    import ann_ctrl_pkg::*;
#(
    parameter int DATAWIDTH = DEFAULT_DATAWIDTH,
    parameter int ROWS      = DEFAULT_ROWS,
    parameter int TIMEOUT   = DEFAULT_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_overall_n,
    ann_layer_sequencer_if.master bus
);
    seq_state_t state;
    seq_state_t state_next;
    logic       timer_clr;
    logic       timer_en;
    logic       timer_expired;
    logic       launch_l1;
    logic       launch_l2;
    logic       capture;
    logic       to_err;

    seq_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_overall_n),
        .clr     (timer_clr),
        .en      (timer_en),
        .expired (timer_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; a completion event in the expiry cycle takes priority over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            IDLE, ERR: if (bus.start) state_next = L1_MAC;
            L1_MAC: begin
                if (bus.mac_done)        state_next = L1_ACT;
                else if (timer_expired)  state_next = ERR;
            end
            L1_ACT: begin
                if (bus.relu_done)       state_next = L2_MAC;
                else if (timer_expired)  state_next = ERR;
            end
            L2_MAC: begin
                if (bus.mac_done)        state_next = L2_ACT;
                else if (timer_expired)  state_next = ERR;
            end
            L2_ACT: begin
                if (bus.relu_done)       state_next = FIN;
                else if (timer_expired)  state_next = ERR;
            end
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Decoded outputs: relu control pins, relu input mux, timer control and transition events.
    always_comb begin
        bus.busy            = is_active(state);
        bus.relu_rst_vals   = 1'b1;
        bus.relu_layer_done = 1'b0;
        bus.relu_in         = bus.l1_acc;
        timer_en            = is_active(state);
        timer_clr           = (state_next != state);
        launch_l1           = ((state == IDLE) || (state == ERR)) && bus.start;
        launch_l2           = (state == L1_ACT) && bus.relu_done;
        capture             = ((state == L1_ACT) || (state == L2_ACT)) && bus.relu_done;
        to_err              = (state_next == ERR) && (state != ERR);
        case (state)
            L1_ACT: begin
                bus.relu_rst_vals   = 1'b0;
                bus.relu_layer_done = 1'b1;
            end
            L2_ACT: begin
                bus.relu_rst_vals   = 1'b0;
                bus.relu_layer_done = 1'b1;
                bus.relu_in         = bus.l2_acc;
            end
            default: ;
        endcase
    end

    // Registered pulses, layer tags, captured activation vector and sticky timeout flag.
    always_ff @(posedge clk or negedge rst_overall_n) begin
        if (!rst_overall_n) begin
            bus.mac_start   <= 1'b0;
            bus.mac_layer   <= LAYER1;
            bus.done        <= 1'b0;
            bus.act_valid   <= 1'b0;
            bus.act_layer   <= LAYER1;
            bus.act_data    <= '0;
            bus.err_timeout <= 1'b0;
        end else begin
            bus.mac_start <= launch_l1 || launch_l2;
            bus.done      <= (state == FIN);
            bus.act_valid <= capture;
            if (launch_l1) begin
                bus.mac_layer <= LAYER1;
            end else if (launch_l2) begin
                bus.mac_layer <= LAYER2;
            end
            if (capture) begin
                bus.act_layer <= (state == L2_ACT) ? LAYER2 : LAYER1;
                bus.act_data  <= bus.relu_out;
            end
            if (to_err) begin
                bus.err_timeout <= 1'b1;
            end else if (launch_l1) begin
                bus.err_timeout <= 1'b0;
            end
        end
    end
endmodule
